sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 11, SRAM address width.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on posedge clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports req0/req1, input, 1, access request per requester; held until the matching ack.
REQ-006 SHALL have ports addr0/addr1, input, ADDRESS_SIZE, request address.
REQ-007 SHALL have ports wdata0/wdata1, input, WIDTH, write data.
REQ-008 SHALL have ports we0/we1, input, 1, 1=write, 0=read.
REQ-009 SHALL have ports ack0/ack1, output, 1, one-cycle completion pulse.
REQ-010 SHALL have ports rdata0/rdata1, output, WIDTH, read data, valid only while the matching ack is high.
REQ-011 SHALL have ports sram_address (ADDRESS_SIZE), sram_data_in (WIDTH), sram_write_enable (1), sram_clock_enable (1), all outputs, driving one ssram instance.
REQ-012 SHALL have port sram_data_out, input, WIDTH, ssram synchronous read data.

Function
REQ-013 SHALL implement two states: IDLE and ACTIVE.
REQ-014 In IDLE with any req high, SHALL select one winner and drive sram_address/sram_data_in from that winner combinationally in the same cycle.
REQ-015 In that same cycle, SHALL assert sram_clock_enable=1 and sram_write_enable=winner's we, register the winner index, and move to ACTIVE.
REQ-016 In IDLE with no req, SHALL hold sram_clock_enable=0 and sram_write_enable=0 and stay in IDLE.
REQ-017 In ACTIVE, SHALL assert ack of the registered winner for exactly that cycle, hold sram_clock_enable=0, and return to IDLE.
REQ-018 SHALL drive rdata0 and rdata1 directly from sram_data_out; read latency is request-issue cycle + 1 (ack cycle).
REQ-019 SHALL also acknowledge writes, one cycle after issue; rdata is don't-care on a write ack.
REQ-020 SHALL sustain at most one access per two cycles, and SHALL NOT grant either port during ACTIVE.
REQ-021 A requester that holds req through its ack cycle SHALL be treated as issuing a new request, arbitrated in the following IDLE cycle.
REQ-022 SHALL give the ack even if the winner's req drops during ACTIVE; the access is not cancelled.
REQ-023 SHALL never assert ack0 and ack1 in the same cycle.

Reset
REQ-024 On reset, SHALL force state=IDLE, ack0=ack1=0, and the round-robin pointer to 1.
REQ-025 While reset is high, SHALL force sram_clock_enable=0 and sram_write_enable=0; no SRAM write may occur in a reset cycle.
REQ-026 Reset asserted in ACTIVE SHALL abandon the ack; a write issued in the preceding cycle remains committed.

Configuration
REQ-027 SHALL support macro ARB_ROUND_ROBIN_EN, which selects the arbitration policy.
REQ-028 With ARB_ROUND_ROBIN_EN defined, a tie SHALL go to the port not granted last; the pointer updates on each grant, and port 0 wins the first tie after reset.
REQ-029 Without ARB_ROUND_ROBIN_EN, port 1 SHALL always win a tie (fixed priority, data over fetch), and no pointer register SHALL exist.

Verification
REQ-030 Write single: req0=1, we0=1, addr0=5, wdata0=0xDEADBEEF -> sram_write_enable=1 at issue; ack0 the next cycle; later read of addr0=5 returns 0xDEADBEEF with ack0 at issue+1.
REQ-031 Simultaneous reads (addr0=1, addr1=2, both held), fixed priority -> ack1 in cycle 2, ack0 in cycle 4; no overlap.
REQ-032 Simultaneous reads (addr0=1, addr1=2, both held), ARB_ROUND_ROBIN_EN -> ack0 first, then ack1, alternating across 8 back-to-back requests (4 acks each).
REQ-033 Reset mid-operation: assert reset in the ACTIVE cycle of a read -> no ack, state IDLE, sram_clock_enable=0 the next cycle.
REQ-034 Reset during issue: reset high with req0=1, we0=1 -> sram_write_enable=0 and the SRAM content is unchanged.
REQ-035 Idle: no req for 10 cycles -> sram_clock_enable=0 and ack0=ack1=0 throughout.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single synchronous SRAM: one access per two cycles.
// Macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise port 1 wins ties.
module sram_arbiter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned ADDRESS_SIZE = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [ADDRESS_SIZE-1:0] addr0,
    input  logic [ADDRESS_SIZE-1:0] addr1,
    input  logic [WIDTH-1:0]        wdata0,
    input  logic [WIDTH-1:0]        wdata1,
    input  logic                    we0,
    input  logic                    we1,
    output logic                    ack0,
    output logic                    ack1,
    output logic [WIDTH-1:0]        rdata0,
    output logic [WIDTH-1:0]        rdata1,
    output logic [ADDRESS_SIZE-1:0] sram_address,
    output logic [WIDTH-1:0]        sram_data_in,
    output logic                    sram_write_enable,
    output logic                    sram_clock_enable,
    input  logic [WIDTH-1:0]        sram_data_out
);

    typedef enum logic {StIdle, StActive} state_e;

    state_e state_q, state_d;
    logic   winner_q, winner_d;
    logic   grant_sel;
    logic   port_sel;

`ifdef ARB_ROUND_ROBIN_EN
    // Last granted port; a tie goes to the other one.
    logic last_q, last_d;

    always_comb begin
        if (req0 && req1) begin
            grant_sel = ~last_q;
        end else begin
            grant_sel = req1;
        end
    end
`else
    always_comb begin
        grant_sel = req1;
    end
`endif

    assign port_sel = (state_q == StIdle) ? grant_sel : winner_q;

    always_comb begin
        state_d           = state_q;
        winner_d          = winner_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d            = last_q;
`endif
        sram_address      = port_sel ? addr1 : addr0;
        sram_data_in      = port_sel ? wdata1 : wdata0;
        sram_clock_enable = 1'b0;
        sram_write_enable = 1'b0;
        ack0              = 1'b0;
        ack1              = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    sram_clock_enable = 1'b1;
                    sram_write_enable = grant_sel ? we1 : we0;
                    winner_d          = grant_sel;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d            = grant_sel;
`endif
                    state_d           = StActive;
                end
            end
            StActive: begin
                ack0    = ~winner_q;
                ack1    = winner_q;
                state_d = StIdle;
            end
        endcase

        // Reset blocks any SRAM access and abandons a pending ack in the same cycle.
        if (reset) begin
            sram_clock_enable = 1'b0;
            sram_write_enable = 1'b0;
            ack0              = 1'b0;
            ack1              = 1'b0;
        end
    end

    assign rdata0 = sram_data_out;
    assign rdata1 = sram_data_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            winner_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SSRAM plus a transaction-level reference model.
// Tie-break expectation follows ARB_ROUND_ROBIN_EN, as in the design.
module tb_sram_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned AS = 6;
    localparam int unsigned NW = 1 << AS;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AS-1:0] addr0, addr1;
    logic [W-1:0]  wdata0, wdata1;
    logic          ack0, ack1;
    logic [W-1:0]  rdata0, rdata1;
    logic [AS-1:0] sram_address;
    logic [W-1:0]  sram_data_in, sram_data_out;
    logic          sram_write_enable, sram_clock_enable;

    always #5 clock = ~clock;

    sram_arbiter #(.WIDTH(W), .ADDRESS_SIZE(AS)) dut (
        .clock             (clock),
        .reset             (reset),
        .req0              (req0),
        .req1              (req1),
        .addr0             (addr0),
        .addr1             (addr1),
        .wdata0            (wdata0),
        .wdata1            (wdata1),
        .we0               (we0),
        .we1               (we1),
        .ack0              (ack0),
        .ack1              (ack1),
        .rdata0            (rdata0),
        .rdata1            (rdata1),
        .sram_address      (sram_address),
        .sram_data_in      (sram_data_in),
        .sram_write_enable (sram_write_enable),
        .sram_clock_enable (sram_clock_enable),
        .sram_data_out     (sram_data_out)
    );

    // Synchronous SRAM attached to the arbiter.
    logic [W-1:0] sram_mem [NW];
    always @(posedge clock) begin
        if (sram_clock_enable) begin
            if (sram_write_enable) sram_mem[sram_address] <= sram_data_in;
            else                   sram_data_out <= sram_mem[sram_address];
        end
    end

    function automatic logic [W-1:0] init_word(int i);
        return 32'hA5000000 ^ (i * 32'h00010203);
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: memory contents, the access awaiting its ack, last granted port.
    logic [W-1:0]  model_mem [NW];
    bit            m_active = 1'b0;
    bit            m_port, m_we;
    logic [AS-1:0] m_addr;
    bit            m_last = 1'b1;
    bit            exp_ack0, exp_ack1;

    function automatic bit pick_winner(bit r0, bit r1);
        if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return ~m_last;
`else
            return 1'b1;
`endif
        end
        return r1;
    endfunction

    // Checks one cycle against the model with the inputs currently applied, then advances.
    task automatic run_cycle();
        bit w;
        #1;
        exp_ack0 = 1'b0;
        exp_ack1 = 1'b0;
        if (reset) begin
            check_eq("rst_ce", sram_clock_enable, 0);
            check_eq("rst_we", sram_write_enable, 0);
            check_eq("rst_ack", {ack1, ack0}, 0);
            m_active = 1'b0;
            m_last   = 1'b1;
        end else if (m_active) begin
            exp_ack0 = (m_port == 1'b0);
            exp_ack1 = (m_port == 1'b1);
            check_eq("act_ack", {ack1, ack0}, {exp_ack1, exp_ack0});
            check_eq("act_ce", sram_clock_enable, 0);
            if (!m_we) begin
                check_eq("rdata", m_port ? rdata1 : rdata0, model_mem[m_addr]);
            end
            m_active = 1'b0;
        end else if (req0 || req1) begin
            w = pick_winner(req0, req1);
            check_eq("iss_ce", sram_clock_enable, 1);
            check_eq("iss_we", sram_write_enable, w ? we1 : we0);
            check_eq("iss_addr", sram_address, w ? addr1 : addr0);
            if (w ? we1 : we0) check_eq("iss_din", sram_data_in, w ? wdata1 : wdata0);
            check_eq("iss_ack", {ack1, ack0}, 0);
            m_active = 1'b1;
            m_port   = w;
            m_we     = w ? we1 : we0;
            m_addr   = w ? addr1 : addr0;
            m_last   = w;
            if (m_we) model_mem[m_addr] = w ? wdata1 : wdata0;
        end else begin
            check_eq("idle_ce", sram_clock_enable, 0);
            check_eq("idle_we", sram_write_enable, 0);
            check_eq("idle_ack", {ack1, ack0}, 0);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic new_req(input int p);
        if (p == 0) begin
            req0 = 1'b1; we0 = $urandom_range(0, 1) == 1;
            addr0 = AS'($urandom); wdata0 = $urandom;
        end else begin
            req1 = 1'b1; we1 = $urandom_range(0, 1) == 1;
            addr1 = AS'($urandom); wdata1 = $urandom;
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            sram_mem[i]  = init_word(i);
            model_mem[i] = init_word(i);
        end
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        @(posedge clock);
        #1;
        run_cycle();
        run_cycle();
        reset = 1'b0;

        // Idle stretch
        for (int i = 0; i < 10; i++) run_cycle();

        // Single write then read-back of address 5
        req0 = 1'b1; we0 = 1'b1; addr0 = 5; wdata0 = 32'hDEADBEEF;
        run_cycle();
        req0 = 1'b0;
        run_cycle();
        req0 = 1'b1; we0 = 1'b0;
        run_cycle();
        req0 = 1'b0;
        run_cycle();

        // Simultaneous reads; port 1 drops after its first ack
        req0 = 1'b1; we0 = 1'b0; addr0 = 1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 2;
        run_cycle();
        run_cycle();
        req1 = 1'b0;
        run_cycle();
        run_cycle();
        req0 = 1'b0;
        run_cycle();

        // Both held for 8 back-to-back grants
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 16; i++) run_cycle();
        req0 = 1'b0; req1 = 1'b0;
        run_cycle();

        // Reset during the ack cycle of a read
        req0 = 1'b1; we0 = 1'b0; addr0 = 5;
        run_cycle();
        req0 = 1'b0; reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        run_cycle();

        // Reset during a write issue must not touch the SRAM
        reset = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 5; wdata0 = 32'h12345678;
        run_cycle();
        reset = 1'b0; req0 = 1'b0;
        run_cycle();
        check_eq("rst_wr_mem", sram_mem[5], 32'hDEADBEEF);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (exp_ack0) begin
                if ($urandom_range(0, 1) == 0) req0 = 1'b0; else new_req(0);
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                new_req(0);
            end
            if (exp_ack1) begin
                if ($urandom_range(0, 1) == 0) req1 = 1'b0; else new_req(1);
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                new_req(1);
            end
            reset = ($urandom_range(0, 63) == 0);
            run_cycle();
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        run_cycle();
        run_cycle();

        for (int i = 0; i < NW; i++) check_eq("mem_final", sram_mem[i], model_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
